// File: rtl/mul_rebuild_seq.sv
// Sequential shift-add multiply-accumulate: product = quotient*divisor + remainder.
// Optional macro MUL_REBUILD_EARLY_EXIT_EN ends RUN as soon as no multiplier bits remain.
module mul_rebuild_seq #(
    parameter int DIVIDEND = 3,
    parameter int DIVISOR  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DIVIDEND-1:0]         quotient,
    input  logic [DIVISOR-1:0]          divisor,
    input  logic [DIVISOR-1:0]          remainder,
    output logic                        busy,
    output logic                        done,
    output logic [DIVIDEND+DIVISOR-1:0] product
);

    localparam int PW = DIVIDEND + DIVISOR;
    localparam int CW = $clog2(DIVISOR + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [PW-1:0]        mcand, mcand_next;
    logic [PW-1:0]        acc, acc_next, acc_sum;
    logic [DIVISOR-1:0]   mplier, mplier_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [PW-1:0]        product_next;
    logic                 busy_next, done_next;
    logic                 finish;

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            mcand   <= mcand_next;
            mplier  <= mplier_next;
            acc     <= acc_next;
            cnt     <= cnt_next;
            product <= product_next;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

    // Next-state, datapath step and output decode
    always_comb begin
        state_next   = state;
        mcand_next   = mcand;
        mplier_next  = mplier;
        acc_next     = acc;
        cnt_next     = cnt;
        product_next = product;
        busy_next    = 1'b0;
        done_next    = 1'b0;
        finish       = 1'b0;
        acc_sum      = mplier[0] ? (acc + mcand) : acc;

        case (state)
            IDLE: begin
                if (start) begin
                    mcand_next  = PW'(quotient);
                    mplier_next = divisor;
                    acc_next    = PW'(remainder);
                    cnt_next    = '0;
                    state_next  = RUN;
                    busy_next   = 1'b1;
                end else begin
                    state_next  = IDLE;
                end
            end
            RUN: begin
                acc_next    = acc_sum;
                mcand_next  = mcand << 1'b1;
                mplier_next = mplier >> 1'b1;
                cnt_next    = cnt + CW'(1);
                busy_next   = 1'b1;
`ifdef MUL_REBUILD_EARLY_EXIT_EN
                finish = (cnt_next == CW'(DIVISOR)) || (mplier_next == '0);
`else
                finish = (cnt_next == CW'(DIVISOR));
`endif
                if (finish) begin
                    // Result includes this cycle's partial-product add
                    product_next = acc_sum;
                    state_next   = DONE;
                    done_next    = 1'b1;
                end else begin
                    state_next   = RUN;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_rebuild_seq.sv
// Directed self-checking bench for mul_rebuild_seq (DIVIDEND=3, DIVISOR=2); also
// valid when built with MUL_REBUILD_EARLY_EXIT_EN, where expected RUN length shrinks.
module tb_mul_rebuild_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] quotient;
    logic [1:0] divisor;
    logic [1:0] remainder;
    logic       busy;
    logic       done;
    logic [4:0] product;

    int n_cmp;
    int n_bad;

    mul_rebuild_seq #(.DIVIDEND(3), .DIVISOR(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edges after the start edge until done is visible
    function automatic int run_len(input int d);
`ifdef MUL_REBUILD_EARLY_EXIT_EN
        return (d >= 2) ? 2 : 1;
`else
        return 2;
`endif
    endfunction

    task automatic do_op(input int q, input int d, input int r, input int exp, input string tag);
        int k;
        @(negedge clk);
        quotient  = 3'(q);
        divisor   = 2'(d);
        remainder = 2'(r);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        quotient  = 3'(~q);
        divisor   = 2'(~d);
        remainder = 2'(~r);
        check_eq({tag, "_busy0"}, int'(busy), 1);
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            check_eq({tag, "_busy"}, int'(busy), 1);
        end
        check_eq({tag, "_lat"}, k, run_len(d));
        check_eq({tag, "_prod"}, int'(product), exp);
        @(posedge clk);
        #1;
        check_eq({tag, "_donelo"}, int'(done), 0);
        check_eq({tag, "_busylo"}, int'(busy), 0);
    endtask

    initial begin
        int k;
        int pulses;
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        quotient  = 3'd0;
        divisor   = 2'd0;
        remainder = 2'd0;
        #12;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_prod", int'(product), 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(5, 3, 2, 17, "t1");
        do_op(7, 3, 3, 24, "t2");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("t2_hold", int'(product), 24);
        end
        do_op(6, 0, 1, 1, "t3");

        // start held high through RUN and DONE with different operands
        @(negedge clk);
        quotient  = 3'd4;
        divisor   = 2'd2;
        remainder = 2'd1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        quotient  = 3'd7;
        divisor   = 2'd3;
        remainder = 2'd3;
        k = 0;
        pulses = 0;
        while (done !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("t4_lat", k, run_len(2));
        check_eq("t4_prod", int'(product), 9);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check_eq("t4_pulses", pulses, 0);
        check_eq("t4_hold", int'(product), 9);
        do_op(7, 3, 3, 24, "t4b");

        // Asynchronous reset one cycle into RUN
        @(negedge clk);
        quotient  = 3'd5;
        divisor   = 2'd3;
        remainder = 2'd2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t5_busy", int'(busy), 0);
        check_eq("t5_done", int'(done), 0);
        check_eq("t5_prod", int'(product), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check_eq("t5_nodone", pulses, 0);
        check_eq("t5_prod2", int'(product), 0);

        for (int q = 0; q < 8; q++)
            for (int d = 0; d < 4; d++)
                for (int r = 0; r < 4; r++)
                    do_op(q, d, r, q * d + r, "sweep");

        for (int dd = 0; dd < 8; dd++)
            for (int dv = 1; dv < 4; dv++)
                do_op(dd / dv, dv, dd % dv, dd, "rebuild");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
